// File: rtl/calc_cmd_sequencer.sv
// Command FIFO + issue/capture/response sequencer in front of the 4-bit calculator.
// Optional feature: define DIV_ZERO_CHECK_EN to answer divide-by-zero locally with rsp_err.
module calc_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             calc_st,
  output logic [1:0]       calc_op,
  output logic [3:0]       calc_a,
  output logic [3:0]       calc_b,
  input  logic [3:0]       calc_result,
  input  logic             calc_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       fifo_op  [FIFO_DEPTH];
  logic [3:0]       fifo_a   [FIFO_DEPTH];
  logic [3:0]       fifo_b   [FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag [FIFO_DEPTH];

  logic push, pop, fifo_empty, head_dz;

  logic [1:0]       iss_op;
  logic [3:0]       iss_a, iss_b;
  logic [TAG_W-1:0] iss_tag;
  logic             iss_dz;

  assign cmd_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid & cmd_ready;

`ifdef DIV_ZERO_CHECK_EN
  assign head_dz = (fifo_op[rd_ptr] == 2'b11) && (fifo_b[rd_ptr] == 4'h0);
`else
  assign head_dz = 1'b0;
`endif

  // A head that is a divide-by-zero skips the calculator and goes straight to CAPTURE.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    calc_st   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head_dz ? CAPTURE : ISSUE;
        end
      end
      ISSUE: begin
        calc_st   = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = head_dz ? CAPTURE : ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]  <= cmd_op;
      fifo_a[wr_ptr]   <= cmd_a;
      fifo_b[wr_ptr]   <= cmd_b;
      fifo_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_op  <= '0;
      iss_a   <= '0;
      iss_b   <= '0;
      iss_tag <= '0;
      iss_dz  <= 1'b0;
    end else if (pop) begin
      iss_op  <= fifo_op[rd_ptr];
      iss_a   <= fifo_a[rd_ptr];
      iss_b   <= fifo_b[rd_ptr];
      iss_tag <= fifo_tag[rd_ptr];
      iss_dz  <= head_dz;
    end
  end

  assign calc_op = iss_op;
  assign calc_a  = iss_a;
  assign calc_b  = iss_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else if (state == CAPTURE) begin
      rsp_valid  <= 1'b1;
      rsp_result <= iss_dz ? 4'h0 : calc_result;
      rsp_carry  <= iss_dz ? 1'b0 : calc_carry;
      rsp_tag    <= iss_tag;
      rsp_err    <= iss_dz;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: calculator stub, timing-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_calc_cmd_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [1:0] cmd_tag = '0;
  logic       calc_st;
  logic [1:0] calc_op;
  logic [3:0] calc_a, calc_b;
  logic [3:0] calc_result;
  logic       calc_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [1:0] rsp_tag;
  logic       rsp_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int st_pulses = 0;
  int st_base = 0;
  int acc_cyc = 0;

  calc_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .calc_st(calc_st), .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
    .calc_result(calc_result), .calc_carry(calc_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Calculator arithmetic: {carry, result}; divide by zero yields carry=1, result=F.
  function automatic logic [4:0] calc_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    case (op)
      2'b00:   calc_fn = {1'b0, a} + {1'b0, b};
      2'b01:   calc_fn = {(a < b), a - b};
      2'b10:   begin p = a * b; calc_fn = {(p > 8'd15), p[3:0]}; end
      default: calc_fn = (b == 4'h0) ? 5'h1F : {1'b0, a / b};
    endcase
  endfunction

  logic [4:0] calc_q;
  always @(posedge clk or negedge rst) begin
    if (!rst)         calc_q <= '0;
    else if (calc_st) calc_q <= calc_fn(calc_op, calc_a, calc_b);
  end
  assign calc_result = calc_q[3:0];
  assign calc_carry  = calc_q[4];

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] tag;
  } cmd_t;

  function automatic bit is_dz(input cmd_t c);
`ifdef DIV_ZERO_CHECK_EN
    return (c.op == 2'b11) && (c.b == 4'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: queued commands plus one in-flight command whose age counts
  // edges since it left the queue (1 = strobe cycle, >=3 = response offered).
  cmd_t mq[$];
  cmd_t cur;
  cmd_t nc;
  bit   busy = 1'b0;
  bit   cur_dz = 1'b0;
  int   age = 0;
  bit   m_acc, m_can_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      busy = 1'b0;
      age  = 0;
    end else begin
      m_acc     = cmd_valid && (mq.size() != DEPTH);
      m_can_pop = !busy || (age >= 3 && rsp_ready);
      if (busy && age >= 3 && rsp_ready) busy = 1'b0;
      else if (busy && age < 3)          age = age + 1;
      if (m_can_pop && mq.size() > 0) begin
        cur    = mq.pop_front();
        busy   = 1'b1;
        cur_dz = is_dz(cur);
        age    = cur_dz ? 2 : 1;
      end
      if (m_acc) begin
        nc.op = cmd_op; nc.a = cmd_a; nc.b = cmd_b; nc.tag = cmd_tag;
        mq.push_back(nc);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  logic [4:0] m_r;
  always @(negedge clk) begin
    if (calc_st) st_pulses++;
    checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, (mq.size() != DEPTH)});
    checkOutput("calc_st",   {31'd0, calc_st},   {31'd0, (busy && age == 1)});
    checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, (busy && age >= 3)});
    if (busy && !cur_dz)
      checkOutput("calc_operands", {22'd0, calc_op, calc_a, calc_b}, {22'd0, cur.op, cur.a, cur.b});
    if (busy && age >= 3 && rsp_valid) begin
      m_r = calc_fn(cur.op, cur.a, cur.b);
      if (cur_dz)
        checkOutput("rsp_fields", {24'd0, rsp_err, rsp_tag, rsp_carry, rsp_result}, {24'd0, 1'b1, cur.tag, 1'b0, 4'h0});
      else
        checkOutput("rsp_fields", {24'd0, rsp_err, rsp_tag, rsp_carry, rsp_result}, {24'd0, 1'b0, cur.tag, m_r[4], m_r[3:0]});
    end
  end

  // Offers one command until accepted; records the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [1:0] tag);
    logic rdy;
    bit   done;
    done    = 1'b0;
    st_base = st_pulses;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk) rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin done = 1'b1; acc_cyc = cyc; end
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  // Waits for one response (rsp_ready held high) and checks it against literals.
  task automatic waitResponse(input string name, input logic [3:0] res, input logic car,
                              input logic [1:0] tag, input logic err, input int pulses);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL %s_timeout: got no rsp_valid expected rsp_valid", name);
    end else begin
      checkOutput({name, "_fields"}, {24'd0, rsp_err, rsp_tag, rsp_carry, rsp_result}, {24'd0, err, tag, car, res});
      checkOutput({name, "_latency"}, cyc - acc_cyc, (pulses == 1) ? 3 : 2);
      checkOutput({name, "_pulses"}, st_pulses - st_base, pulses);
    end
    @(posedge clk); #1;
  endtask

  int k;
  int nseen;
  int prev_cyc;
  logic rdy;
  bit got;

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs", {29'd0, cmd_ready, rsp_valid, calc_st}, 32'b100);
    end
    @(posedge clk); #1;

    // Single commands with hand-computed results
    rsp_ready = 1'b1;
    applyStimulus(2'b00, 4'd7, 4'd5, 2'd1);  waitResponse("add_7_5",   4'hC, 1'b0, 2'd1, 1'b0, 1);
    applyStimulus(2'b00, 4'hF, 4'd1, 2'd2);  waitResponse("add_F_1",   4'h0, 1'b1, 2'd2, 1'b0, 1);
    applyStimulus(2'b01, 4'd2, 4'd3, 2'd3);  waitResponse("sub_2_3",   4'hF, 1'b1, 2'd3, 1'b0, 1);
    applyStimulus(2'b10, 4'd3, 4'd5, 2'd0);  waitResponse("mul_3_5",   4'hF, 1'b0, 2'd0, 1'b0, 1);
    applyStimulus(2'b11, 4'd9, 4'd0, 2'd2);
`ifdef DIV_ZERO_CHECK_EN
    waitResponse("div_9_0", 4'h0, 1'b0, 2'd2, 1'b1, 0);
`else
    waitResponse("div_9_0", 4'hF, 1'b1, 2'd2, 1'b0, 1);
`endif
    applyStimulus(2'b11, 4'd9, 4'd2, 2'd1);  waitResponse("div_9_2",   4'h4, 1'b0, 2'd1, 1'b0, 1);

    // Fill with the response port stalled
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12 && k < 7; c++) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = k[3:0]; cmd_b = 4'd1; cmd_tag = k[1:0];
      @(negedge clk) rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) k++;
    end
    cmd_valid = 1'b0;
    checkOutput("fill_accepted", k, 5);
    @(negedge clk);
    checkOutput("fill_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (rsp_valid) got = 1'b1;
      end
      if (!got) begin
        checks++; errors++;
        $display("[TB] FAIL drain_timeout: got no rsp_valid expected response %0d", n);
      end else begin
        checkOutput("drain_tag", {30'd0, rsp_tag}, n % 4);
        checkOutput("drain_result", {28'd0, rsp_result}, n + 1);
        if (n > 0) checkOutput("drain_spacing", cyc - prev_cyc, 3);
        prev_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk); #1;

    // Reset while the head command is in CAPTURE with two more queued
    k = 0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd2; cmd_b = k[3:0]; cmd_tag = k[1:0];
      @(negedge clk) rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) k++;
    end
    cmd_valid = 1'b0;
    checkOutput("rst_setup_accepted", k, 3);
    rst = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    nseen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid || calc_st) nseen++;
    end
    checkOutput("rst_no_response", nseen, 0);
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_a     = 4'($urandom_range(0, 15));
      cmd_b     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cmd_tag   = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 99) < 65);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) @(posedge clk); #1;
    checkOutput("final_drained", {31'd0, busy} + mq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
